enc_key_sched_seq_256: RTL
==========================

Name: enc_key_sched_seq_256

Overview:
- Sequential encryption-side round-key generator for SWAN256; the forward counterpart of the decryption key-schedule step.
- Loads a 256-bit master key and emits ROUNDS 128-bit subkeys, one per accepted valid/ready handshake, in encryption order.
- On completion, exposes the final key/delta state, from which the decryption schedule starts when it walks the subkeys in reverse.

Parameters:
- KEY_SIZE, 256, master key width.
- SIDE_SIZE, 128, subkey/delta width.
- PD, 120, left-rotation amount per round (the inverse of the decryption-side right rotation).
- ROUNDS, 64, subkeys emitted per key load; legal range 1..255.
- DELTA_INIT, 128'h9e3779b97f4a7c15f39cc0605cedc834, delta value used in round 1.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load request; honoured only in IDLE.
- key_in  input  [0:KEY_SIZE-1]  master key, sampled with start; bit 0 is the MSB.
- busy  output  1  high in GEN and FIN.
- sk  output  [0:SIDE_SIZE-1]  current subkey.
- sk_valid  output  1  sk is valid.
- sk_ready  input  1  consumer accepts sk.
- sk_idx  output  8  round index of sk, 0-based.
- done  output  1  one-cycle pulse after the last subkey is accepted.

Behaviour:
- Reset: state=IDLE; key_r=0; delta_r=0; cnt=0; busy=0; sk_valid=0; done=0.
- Reset value of sk: sk is the combinational step output, so it is not forced. It is valid only while sk_valid=1.
- Step function, all arithmetic mod 2^128, no carry out:
  - t = rotl(key_r, PD), i.e. {key_r[PD:255], key_r[0:PD-1]}.
  - sk = t[128:255] + delta_r.
  - next_key = {t[0:127], sk}.
  - next_delta = delta_r + DELTA0, with DELTA0 = 128'h9e3779b97f4a7c15f39cc0605cedc834.
- IDLE:
  - start=1 -> key_r<=key_in; delta_r<=DELTA_INIT; cnt<=0; go to GEN.
  - The first sk_valid appears the next cycle (latency 1).
- GEN:
  - sk_valid=1; sk_idx=cnt.
  - sk_ready=0 -> all state and sk are held stable.
  - Handshake with cnt<ROUNDS-1 -> key_r<=next_key; delta_r<=next_delta; cnt++.
  - Handshake with cnt==ROUNDS-1 -> key_r<=next_key; delta_r is not advanced; go to FIN. delta_r then holds the delta used in the last round.
  - One subkey per cycle is sustained while sk_ready=1.
- FIN: done=1, sk_valid=0 for exactly one cycle, then IDLE.
- start is ignored in GEN and FIN.
- rst mid-run aborts immediately. No done pulse; the partial state is discarded.
- ROUNDS=1: a single handshake, then FIN.
- Round-trip property: applying the decryption step to (final key, final delta) reproduces the subkeys in reverse order.

Optional Feature:
- Macro SWAN256_KS_FINAL_STATE_EN.
- Defined: adds two output ports.
  - final_key [0:KEY_SIZE-1] = key_r.
  - final_delta [0:SIDE_SIZE-1] = delta_r.
  - Both are valid from the done cycle, held until the next accepted start, and reset to 0.
- Undefined: the ports and their logic are absent. Core behaviour is unchanged.

Decomposition:
- Package swan256_pkg:
  - DELTA0, KEY_SIZE/SIDE_SIZE constants.
  - PD.
  - State enum {IDLE, GEN, FIN}.
- Sub-module enc_key_round_256: the pure combinational step (key_r, delta_r -> sk, next_key, next_delta). It is instantiated once and unit-tested against the decryption step as its inverse.

Test Plan:
- key_in=0, start, sk_ready=1 -> sk_idx0 sk=128'h9e3779b97f4a7c15f39cc0605cedc834; internal delta then 128'h3c6ef372fe94f82be73980c0b9db9068.
- key_in=256'hFF..FF, start -> round0 sk=128'h9e3779b97f4a7c15f39cc0605cedc833 (mod wrap); upper 128 of next_key all ones.
- Random key, ROUNDS=64, sk_ready random -> 64 subkeys, idx 0..63 with no gaps or repeats; sk stable while sk_ready=0; done exactly once, 1 cycle after the last accept.
- With SWAN256_KS_FINAL_STATE_EN: feed final_key/final_delta into the decryption-step model 64 times -> subkeys equal the captured list reversed; final key returns to key_in.
- start asserted during GEN -> ignored, sequence unaffected; rst at idx 10 -> sk_valid=0 and busy=0 the next cycle, no done; a new start restarts at idx 0 with the round0 value.
- ROUNDS=1 build -> one handshake, done pulse, then back to IDLE accepting start on the following cycle.

Source files
------------

// File: rtl/swan256_pkg.sv
// Shared constants, state encoding for the SWAN256 encryption key schedule.
// Optional final-state ports: SWAN256_KS_FINAL_STATE_EN.
package swan256_pkg;

    localparam int KEY_SIZE  = 256;
    localparam int SIDE_SIZE = 128;
    localparam int PD        = 120;

    localparam logic [0:SIDE_SIZE-1] DELTA0 =
        128'h9e3779b97f4a7c15f39cc0605cedc834;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        FIN
    } state_e;

endpackage

// File: rtl/enc_key_sched_seq_256_round.sv
// Pure combinational SWAN256 encryption key-schedule step.
// Bit 0 is the MSB of every vector.
module enc_key_round_256
    import swan256_pkg::*;
(
    input  logic [0:KEY_SIZE-1]  key_r,
    input  logic [0:SIDE_SIZE-1] delta_r,
    output logic [0:SIDE_SIZE-1] sk,
    output logic [0:KEY_SIZE-1]  next_key,
    output logic [0:SIDE_SIZE-1] next_delta
);

    logic [0:KEY_SIZE-1] t;

    assign t          = {key_r[PD:KEY_SIZE-1], key_r[0:PD-1]};
    assign sk         = t[SIDE_SIZE:KEY_SIZE-1] + delta_r;
    assign next_key   = {t[0:SIDE_SIZE-1], sk};
    assign next_delta = delta_r + DELTA0;

endmodule

// File: rtl/enc_key_sched_seq_256.sv
// Sequential SWAN256 round-key generator, one subkey per handshake.
// Optional macro SWAN256_KS_FINAL_STATE_EN exposes final_key/final_delta.
module enc_key_sched_seq_256
    import swan256_pkg::*;
#(
    parameter int                   ROUNDS     = 64,
    parameter logic [0:SIDE_SIZE-1] DELTA_INIT = DELTA0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [0:KEY_SIZE-1]  key_in,
    output logic                 busy,
    output logic [0:SIDE_SIZE-1] sk,
    output logic                 sk_valid,
    input  logic                 sk_ready,
    output logic [7:0]           sk_idx,
    output logic                 done
`ifdef SWAN256_KS_FINAL_STATE_EN
    ,
    output logic [0:KEY_SIZE-1]  final_key,
    output logic [0:SIDE_SIZE-1] final_delta
`endif
);

    localparam logic [7:0] LAST = 8'(ROUNDS - 1);

    state_e               state_q, state_d;
    logic [0:KEY_SIZE-1]  key_q, key_d;
    logic [0:SIDE_SIZE-1] delta_q, delta_d;
    logic [7:0]           cnt_q, cnt_d;

    logic [0:KEY_SIZE-1]  next_key;
    logic [0:SIDE_SIZE-1] next_delta;

    enc_key_round_256 u_round (
        .key_r      (key_q),
        .delta_r    (delta_q),
        .sk         (sk),
        .next_key   (next_key),
        .next_delta (next_delta)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            delta_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            delta_q <= delta_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        delta_d = delta_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    delta_d = DELTA_INIT;
                    cnt_d   = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (sk_ready) begin
                    key_d = next_key;
                    // Last round keeps its delta so the reverse walk starts here
                    if (cnt_q == LAST) begin
                        state_d = FIN;
                    end else begin
                        delta_d = next_delta;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        sk_valid = (state_q == GEN);
        done     = (state_q == FIN);
        sk_idx   = cnt_q;
    end

`ifdef SWAN256_KS_FINAL_STATE_EN
    assign final_key   = key_q;
    assign final_delta = delta_q;
`endif

endmodule
